// File: rtl/mist_sd_arbiter.sv
// Round-robin owner of the single hps_io virtual-disk channel: one sector transfer at a time.
// Define MIST_SDARB_TIMEOUT_EN to add an ISSUE-state ack watchdog with req_err abort pulses.
module mist_sd_arbiter #(
    parameter int NREQ = 4,
    parameter int TO_W = 24
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_rd,
    input  logic [NREQ-1:0]     req_wr,
    input  logic [32*NREQ-1:0]  req_lba,
    input  logic [8*NREQ-1:0]   req_buff_din,
    output logic [NREQ-1:0]     req_buff_wr,
    output logic [NREQ-1:0]     req_done,
    output logic [NREQ-1:0]     req_err,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic [31:0]         sd_lba,
    output logic [NREQ-1:0]     sd_rd,
    output logic [NREQ-1:0]     sd_wr,
    input  logic                sd_ack,
    input  logic                sd_buff_wr,
    output logic [7:0]          sd_buff_din
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_XFER,
        ST_DONE,
        ST_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   sd_rd_q, sd_rd_d;
    logic [NREQ-1:0]   sd_wr_q, sd_wr_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [31:0]       lba_q, lba_d;
    logic [IDX_W-1:0]  last_q, last_d;

    logic [NREQ-1:0]   pending;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;
    logic [31:0]       lba_arr [NREQ];
    logic [7:0]        din_arr [NREQ];
    logic [7:0]        buff_din;

    // TO_W must be at least 1 for the watchdog counter to exist.
    if (TO_W < 1) begin : g_to_w_invalid
    end

`ifdef MIST_SDARB_TIMEOUT_EN
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [TO_W-1:0]   to_inc;
    logic [NREQ-1:0]   err_q, err_d;

    assign to_inc = to_cnt_q + TO_W'(1);
`endif

    assign pending = req_rd | req_wr;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            lba_arr[i] = req_lba[32*i +: 32];
            din_arr[i] = req_buff_din[8*i +: 8];
        end
    end

    // Descending scan so the candidate nearest to last_q+1 is the final winner.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_q) + k) % NREQ);
            if (pending[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        buff_din = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                buff_din = buff_din | din_arr[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sd_rd_d = sd_rd_q;
        sd_wr_d = sd_wr_q;
        done_d  = '0;
        lba_d   = lba_q;
        last_d  = last_q;
`ifdef MIST_SDARB_TIMEOUT_EN
        err_d    = '0;
        to_cnt_d = to_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    lba_d             = lba_arr[pick_idx];
                    sd_rd_d           = '0;
                    sd_wr_d           = '0;
                    if (req_wr[pick_idx]) begin
                        sd_wr_d[pick_idx] = 1'b1;
                    end else begin
                        sd_rd_d[pick_idx] = 1'b1;
                    end
                    last_d  = pick_idx;
                    state_d = ST_ISSUE;
`ifdef MIST_SDARB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            ST_ISSUE: begin
                if (sd_ack) begin
                    sd_rd_d = '0;
                    sd_wr_d = '0;
                    state_d = ST_XFER;
                end
`ifdef MIST_SDARB_TIMEOUT_EN
                // Unmounted images never ack; abort once the counter reaches all-ones.
                else if (&to_inc) begin
                    sd_rd_d = '0;
                    sd_wr_d = '0;
                    done_d  = grant_q;
                    err_d   = grant_q;
                    state_d = ST_DONE;
                end else begin
                    to_cnt_d = to_inc;
                end
`endif
            end
            ST_XFER: begin
                if (!sd_ack) begin
                    done_d  = grant_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sd_rd_q <= '0;
            sd_wr_q <= '0;
            done_q  <= '0;
            lba_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sd_rd_q <= sd_rd_d;
            sd_wr_q <= sd_wr_d;
            done_q  <= done_d;
            lba_q   <= lba_d;
            last_q  <= last_d;
        end
    end

`ifdef MIST_SDARB_TIMEOUT_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
            err_q    <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign req_err = err_q;
`else
    assign req_err = '0;
`endif

    assign grant       = grant_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign sd_lba      = lba_q;
    assign req_done    = done_q;
    assign busy        = (state_q != ST_IDLE);
    assign req_buff_wr = {NREQ{sd_buff_wr & sd_ack}} & grant_q;
    assign sd_buff_din = buff_din;

endmodule

// File: tb/tb_mist_sd_arbiter.sv
// Scoreboard bench for mist_sd_arbiter: grants and completions are queued as expectations
// and popped by a monitor; the timeout scenario follows MIST_SDARB_TIMEOUT_EN.
module tb_mist_sd_arbiter;
    localparam int NREQ = 4;

    logic                clk_sys = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_rd;
    logic [NREQ-1:0]     req_wr;
    logic [32*NREQ-1:0]  req_lba;
    logic [8*NREQ-1:0]   req_buff_din;
    logic [NREQ-1:0]     req_buff_wr;
    logic [NREQ-1:0]     req_done;
    logic [NREQ-1:0]     req_err;
    logic [NREQ-1:0]     grant;
    logic                busy;
    logic [31:0]         sd_lba;
    logic [NREQ-1:0]     sd_rd;
    logic [NREQ-1:0]     sd_wr;
    logic                sd_ack;
    logic                sd_buff_wr;
    logic [7:0]          sd_buff_din;

    mist_sd_arbiter #(.NREQ(NREQ), .TO_W(4)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_lba      (req_lba),
        .req_buff_din (req_buff_din),
        .req_buff_wr  (req_buff_wr),
        .req_done     (req_done),
        .req_err      (req_err),
        .grant        (grant),
        .busy         (busy),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [3:0]  grant;
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic [31:0] lba;
    } grant_exp_t;

    typedef struct packed {
        logic [3:0] done;
        logic [3:0] err;
    } done_exp_t;

    grant_exp_t exp_grant_q[$];
    done_exp_t  exp_done_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int bw_cnt [NREQ];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic void pushExpect(input logic [3:0] g, input logic [3:0] rd, input logic [3:0] wr,
                                       input logic [31:0] lba, input logic [3:0] err);
        grant_exp_t ge;
        done_exp_t  de;
        ge.grant = g;
        ge.rd    = rd;
        ge.wr    = wr;
        ge.lba   = lba;
        de.done  = g;
        de.err   = err;
        exp_grant_q.push_back(ge);
        exp_done_q.push_back(de);
    endfunction

    task automatic applyStimulus(input logic [3:0] rd_set, input logic [3:0] wr_set);
        req_rd = req_rd | rd_set;
        req_wr = req_wr | wr_set;
    endtask

    // Monitor: pops an expectation whenever the DUT raises a channel request or a done pulse.
    initial begin : monitor
        logic [3:0] prev_req;
        grant_exp_t ge;
        done_exp_t  de;
        prev_req = '0;
        forever begin
            @(negedge clk_sys);
            for (int k = 0; k < NREQ; k++) if (req_buff_wr[k]) bw_cnt[k]++;
            if ((sd_rd | sd_wr) != 4'b0 && prev_req == 4'b0) begin
                if (exp_grant_q.size() == 0) begin
                    checkOutput("unexpected_grant", {sd_rd, sd_wr}, 64'h0);
                end else begin
                    ge = exp_grant_q.pop_front();
                    checkOutput("grant", grant, ge.grant);
                    checkOutput("sd_rd", sd_rd, ge.rd);
                    checkOutput("sd_wr", sd_wr, ge.wr);
                    checkOutput("sd_lba", sd_lba, ge.lba);
                end
            end
            prev_req = sd_rd | sd_wr;
            if (req_done != 4'b0) begin
                if (exp_done_q.size() == 0) begin
                    checkOutput("unexpected_done", req_done, 64'h0);
                end else begin
                    de = exp_done_q.pop_front();
                    checkOutput("req_done", req_done, de.done);
                    checkOutput("req_err", req_err, de.err);
                end
            end
        end
    end

    // Requesters drop their request when they see req_done.
    initial begin : dropper
        forever begin
            @(negedge clk_sys);
            for (int i = 0; i < NREQ; i++) begin
                if (req_done[i]) begin
                    req_rd[i] = 1'b0;
                    req_wr[i] = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitIssue();
        int guard;
        guard = 0;
        while ((sd_rd | sd_wr) == 4'b0 && guard < 20) begin
            @(posedge clk_sys); #1;
            guard++;
        end
        checkOutput("issue_wait", (guard < 20), 1);
    endtask

    task automatic serveHps(input logic [3:0] g, input logic [31:0] lba, input logic [7:0] din,
                            input int ack_dly, input int nbytes, input bit drop);
        int other;
        for (int k = 0; k < NREQ; k++) bw_cnt[k] = 0;
        waitIssue();
        checkOutput("busy_issue", busy, 1);
        if (drop) begin
            req_rd  = req_rd & ~g;
            req_wr  = req_wr & ~g;
            req_lba = ~req_lba;
        end
        sd_buff_wr = 1'b1;
        @(posedge clk_sys); #1;
        sd_buff_wr = 1'b0;
        repeat (ack_dly) @(posedge clk_sys);
        #1;
        sd_ack = 1'b1;
        @(posedge clk_sys); #1;
        checkOutput("rdwr_clear", {sd_rd, sd_wr}, 64'h0);
        checkOutput("xfer_lba", sd_lba, lba);
        checkOutput("xfer_din", sd_buff_din, din);
        for (int b = 0; b < nbytes; b++) begin
            sd_buff_wr = 1'b1;
            @(posedge clk_sys); #1;
            sd_buff_wr = 1'b0;
            @(posedge clk_sys); #1;
        end
        sd_ack = 1'b0;
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        checkOutput("gap_grant", grant, g);
        checkOutput("gap_done", req_done, 64'h0);
        @(posedge clk_sys); #1;
        checkOutput("idle_grant", grant, 64'h0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_din", sd_buff_din, 64'h0);
        other = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (g[k]) checkOutput("bw_granted", bw_cnt[k], nbytes);
            else other += bw_cnt[k];
        end
        checkOutput("bw_others", other, 0);
    endtask

    initial begin : stimulus
        int cyc;
        reset        = 1'b0;
        req_rd       = '0;
        req_wr       = '0;
        req_lba      = '0;
        req_buff_din = 32'h4433A53C;
        sd_ack       = 1'b0;
        sd_buff_wr   = 1'b0;
        #1 reset = 1'b1;
        #2;
        checkOutput("rst_grant", grant, 64'h0);
        checkOutput("rst_sd_rdwr", {sd_rd, sd_wr}, 64'h0);
        checkOutput("rst_sd_lba", sd_lba, 64'h0);
        checkOutput("rst_done_err", {req_done, req_err}, 64'h0);
        checkOutput("rst_busy", busy, 0);
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;
        @(posedge clk_sys); #1;

        $display("[TB] single read on requester 0");
        req_lba[31:0] = 32'h12;
        pushExpect(4'b0001, 4'b0001, 4'b0000, 32'h12, 4'b0000);
        applyStimulus(4'b0001, 4'b0000);
        serveHps(4'b0001, 32'h12, 8'h3C, 3, 4, 1'b0);

        $display("[TB] single read on requester 3");
        req_lba[127:96] = 32'h33;
        pushExpect(4'b1000, 4'b1000, 4'b0000, 32'h33, 4'b0000);
        applyStimulus(4'b1000, 4'b0000);
        serveHps(4'b1000, 32'h33, 8'h44, 1, 2, 1'b0);

        $display("[TB] round robin 0,1,3 then 0,1");
        req_lba = {32'h103, 32'h102, 32'h101, 32'h100};
        pushExpect(4'b0001, 4'b0001, 4'b0000, 32'h100, 4'b0000);
        pushExpect(4'b0010, 4'b0010, 4'b0000, 32'h101, 4'b0000);
        pushExpect(4'b1000, 4'b1000, 4'b0000, 32'h103, 4'b0000);
        applyStimulus(4'b1011, 4'b0000);
        serveHps(4'b0001, 32'h100, 8'h3C, 1, 2, 1'b0);
        serveHps(4'b0010, 32'h101, 8'hA5, 1, 2, 1'b0);
        serveHps(4'b1000, 32'h103, 8'h44, 1, 2, 1'b0);
        pushExpect(4'b0001, 4'b0001, 4'b0000, 32'h100, 4'b0000);
        pushExpect(4'b0010, 4'b0010, 4'b0000, 32'h101, 4'b0000);
        applyStimulus(4'b0011, 4'b0000);
        serveHps(4'b0001, 32'h100, 8'h3C, 1, 1, 1'b0);
        serveHps(4'b0010, 32'h101, 8'hA5, 1, 1, 1'b0);

        $display("[TB] full sector read routed to requester 2");
        pushExpect(4'b0100, 4'b0100, 4'b0000, 32'h102, 4'b0000);
        applyStimulus(4'b0100, 4'b0000);
        serveHps(4'b0100, 32'h102, 8'h33, 1, 512, 1'b0);

        $display("[TB] spurious ack in idle, then write on requester 1");
        sd_ack = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        checkOutput("spurious_busy", busy, 0);
        checkOutput("spurious_grant", grant, 64'h0);
        sd_ack = 1'b0;
        @(posedge clk_sys); #1;
        req_lba[63:32] = 32'h2222;
        pushExpect(4'b0010, 4'b0000, 4'b0010, 32'h2222, 4'b0000);
        applyStimulus(4'b0010, 4'b0010);
        serveHps(4'b0010, 32'h2222, 8'hA5, 2, 8, 1'b1);

        $display("[TB] reset during transfer");
        req_lba = {32'h0, 32'h0, 32'h0, 32'h55};
        pushExpect(4'b0001, 4'b0001, 4'b0000, 32'h55, 4'b0000);
        applyStimulus(4'b0001, 4'b0000);
        waitIssue();
        sd_ack = 1'b1;
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        reset = 1'b1;
        #1;
        checkOutput("arst_grant", grant, 64'h0);
        checkOutput("arst_sd_rdwr", {sd_rd, sd_wr}, 64'h0);
        checkOutput("arst_sd_lba", sd_lba, 64'h0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_done", req_done, 64'h0);
        sd_ack = 1'b0;
        req_rd = '0;
        exp_done_q.delete(exp_done_q.size() - 1);
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        reset = 1'b0;
        req_lba[127:96] = 32'h77;
        pushExpect(4'b1000, 4'b1000, 4'b0000, 32'h77, 4'b0000);
        applyStimulus(4'b1000, 4'b0000);
        serveHps(4'b1000, 32'h77, 8'h44, 1, 2, 1'b0);

        $display("[TB] write with no ack on requester 1");
        req_lba[63:32] = 32'h99;
`ifdef MIST_SDARB_TIMEOUT_EN
        pushExpect(4'b0010, 4'b0000, 4'b0010, 32'h99, 4'b0010);
`else
        pushExpect(4'b0010, 4'b0000, 4'b0010, 32'h99, 4'b0000);
        exp_done_q.delete(exp_done_q.size() - 1);
`endif
        applyStimulus(4'b0000, 4'b0010);
        waitIssue();
`ifdef MIST_SDARB_TIMEOUT_EN
        cyc = 0;
        while (sd_wr[1] && cyc < 100) begin
            cyc++;
            @(posedge clk_sys); #1;
        end
        checkOutput("to_issue_cycles", cyc, 15);
        checkOutput("to_done_err", {req_done, req_err}, 64'h22);
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        checkOutput("to_idle_grant", grant, 64'h0);
        checkOutput("to_idle_busy", busy, 0);
`else
        cyc = 0;
        repeat (40) begin
            @(posedge clk_sys); #1;
            cyc++;
        end
        checkOutput("noto_sd_wr", sd_wr, 64'h2);
        checkOutput("noto_req_err", req_err, 64'h0);
        checkOutput("noto_busy", busy, 1);
        req_wr = '0;
        reset  = 1'b1;
        #1;
        checkOutput("noto_rst_sd_wr", sd_wr, 64'h0);
        @(posedge clk_sys); #1;
        reset = 1'b0;
`endif
        repeat (4) @(posedge clk_sys);
        #1;
        checkOutput("grant_queue_empty", exp_grant_q.size(), 0);
        checkOutput("done_queue_empty", exp_done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
